// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-control bundle between the hazard sequencer and the datapath.
// The slave modport is the sequencer side, the master modport the datapath side.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       ex_reg_addr;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic [1:0]       mem_ls;
    logic             dmem_ready;
    logic             dmem_req;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_reg_addr, ex_mem_read, ex_branch_taken,
        input  mem_ls, dmem_ready,
        output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, mem_wb_bubble, bus_err, stall_cnt
    );

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_reg_addr, ex_mem_read, ex_branch_taken,
        output mem_ls, dmem_ready,
        input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, mem_wb_bubble, bus_err, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes and freezes for multi-cycle data-memory accesses, with a sticky
// memory-timeout error and a count of cycles in which the PC did not advance.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_ERROR    = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       wait_cnt;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;

    logic mem_op;
    logic freeze;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;

    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_bubble;
    logic dmem_req;

    // Hazard detection terms; x0 is never a real dependency.
    always_comb begin
        mem_op   = (hz.mem_ls == 2'b01) || (hz.mem_ls == 2'b10);
        freeze   = (state != S_ERROR) && mem_op && !hz.dmem_ready;
        rs1_hit  = hz.id_rs1_used && (hz.id_rs1 == hz.ex_reg_addr);
        rs2_hit  = hz.id_rs2_used && (hz.id_rs2 == hz.ex_reg_addr);
        load_use = hz.ex_mem_read && (hz.ex_reg_addr != 5'd0) && (rs1_hit || rs2_hit);
    end

    // Pipeline controls by priority: reset, error, freeze, branch, load-use, normal.
    // Branch and load-use inputs are simply ignored while frozen, so they take
    // effect again on the first unfrozen cycle without any extra state.
    always_comb begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b0;
        dmem_req      = 1'b0;
        if (!rst) begin
            dmem_req = mem_op && (state != S_ERROR);
            if (state == S_ERROR || freeze) begin
                mem_wb_bubble = 1'b1;
            end else if (hz.ex_branch_taken) begin
                pc_en       = 1'b1;
                if_id_en    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                id_ex_flush = 1'b1;
                ex_mem_en   = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
            end
        end
    end

    // Sequencer state, memory-wait timer, sticky error and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            wait_cnt  <= '0;
            bus_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                S_RUN: begin
                    if (freeze) begin
                        state    <= S_MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!mem_op || hz.dmem_ready) begin
                        state    <= S_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        state   <= S_ERROR;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_ERROR: begin
                    state <= S_ERROR;
                end
                default: begin
                    state    <= S_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign hz.pc_en         = pc_en;
    assign hz.if_id_en      = if_id_en;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_en      = id_ex_en;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_en     = ex_mem_en;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.dmem_req      = dmem_req;
    assign hz.bus_err       = bus_err;
    assign hz.stall_cnt     = stall_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4 and a 4-bit stall counter
// so that the timeout and the counter wrap are both reachable in a short run.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   passes;
    int   total;

    pipe_hazard_ctrl_if #(.CNT_W(4)) hz ();

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    // Control vector order: pc_en, if_id_en, if_id_flush, id_ex_en,
    // id_ex_flush, ex_mem_en, mem_wb_bubble, dmem_req
    localparam logic [7:0] C_ZERO   = 8'b0000_0000;
    localparam logic [7:0] C_NORM   = 8'b1101_0100;
    localparam logic [7:0] C_NORM_R = 8'b1101_0101;
    localparam logic [7:0] C_LU     = 8'b0001_1100;
    localparam logic [7:0] C_BR     = 8'b1111_1100;
    localparam logic [7:0] C_BR_R   = 8'b1111_1101;
    localparam logic [7:0] C_FRZ    = 8'b0000_0011;
    localparam logic [7:0] C_ERR    = 8'b0000_0010;

    logic [7:0] ctrl;
    assign ctrl = {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en,
                   hz.id_ex_flush, hz.ex_mem_en, hz.mem_wb_bubble, hz.dmem_req};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: outputs checked mid-cycle, registered state after the edge.
    task automatic cyc(input string tag, input logic [7:0] ec, input logic [3:0] es, input logic ee);
        @(negedge clk);
        chk({tag, ".ctrl"}, 32'(ctrl), 32'(ec));
        @(posedge clk);
        #1;
        chk({tag, ".stall"}, 32'(hz.stall_cnt), 32'(es));
        chk({tag, ".err"}, 32'(hz.bus_err), 32'(ee));
    endtask

    task automatic idle_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_reg_addr = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
        hz.mem_ls = 2'b00; hz.dmem_ready = 1'b0;
    endtask

    initial begin
        passes = 0;
        total  = 0;
        idle_inputs();

        // Reset with active inputs: everything forced low
        rst = 1'b1;
        hz.mem_ls = 2'b01; hz.ex_branch_taken = 1'b1;
        cyc("rst0", C_ZERO, 4'd0, 1'b0);
        cyc("rst1", C_ZERO, 4'd0, 1'b0);
        rst = 1'b0;
        idle_inputs();
        cyc("idle", C_NORM, 4'd0, 1'b0);

        // Load-use on rs2
        hz.ex_mem_read = 1'b1; hz.ex_reg_addr = 5'd5; hz.id_rs2 = 5'd5; hz.id_rs2_used = 1'b1;
        cyc("lu_rs2", C_LU, 4'd1, 1'b0);
        // Same pattern on x0: no hazard
        hz.ex_reg_addr = 5'd0; hz.id_rs2 = 5'd0;
        cyc("lu_x0", C_NORM, 4'd1, 1'b0);
        // rs1 matches but is unused
        hz.ex_reg_addr = 5'd7; hz.id_rs1 = 5'd7; hz.id_rs1_used = 1'b0; hz.id_rs2 = 5'd3;
        cyc("lu_unused", C_NORM, 4'd1, 1'b0);
        hz.id_rs1_used = 1'b1;
        cyc("lu_rs1", C_LU, 4'd2, 1'b0);
        // Branch squashes a simultaneous load-use
        hz.ex_branch_taken = 1'b1;
        cyc("br_lu", C_BR, 4'd2, 1'b0);

        // Zero-latency access and reserved encoding
        idle_inputs();
        hz.mem_ls = 2'b01; hz.dmem_ready = 1'b1;
        cyc("zero_lat", C_NORM_R, 4'd2, 1'b0);
        hz.mem_ls = 2'b11; hz.dmem_ready = 1'b0;
        cyc("ls_resv", C_NORM, 4'd2, 1'b0);

        // Three-cycle load wait with a branch held across the freeze
        hz.mem_ls = 2'b01; hz.ex_branch_taken = 1'b1;
        cyc("wait1", C_FRZ, 4'd3, 1'b0);
        cyc("wait2", C_FRZ, 4'd4, 1'b0);
        cyc("wait3", C_FRZ, 4'd5, 1'b0);
        hz.dmem_ready = 1'b1;
        cyc("wait_rdy", C_BR_R, 4'd5, 1'b0);
        idle_inputs();
        cyc("post_wait", C_NORM, 4'd5, 1'b0);

        // Store that never completes: error on the fourth frozen edge
        hz.mem_ls = 2'b10;
        cyc("to1", C_FRZ, 4'd6, 1'b0);
        cyc("to2", C_FRZ, 4'd7, 1'b0);
        cyc("to3", C_FRZ, 4'd8, 1'b0);
        cyc("to4", C_FRZ, 4'd9, 1'b1);
        cyc("err1", C_ERR, 4'd10, 1'b1);
        hz.mem_ls = 2'b01; hz.dmem_ready = 1'b1;
        cyc("err_rdy", C_ERR, 4'd11, 1'b1);
        cyc("err3", C_ERR, 4'd12, 1'b1);
        cyc("err4", C_ERR, 4'd13, 1'b1);
        cyc("err5", C_ERR, 4'd14, 1'b1);
        cyc("err6", C_ERR, 4'd15, 1'b1);
        cyc("wrap", C_ERR, 4'd0, 1'b1);
        rst = 1'b1;
        cyc("err_rst", C_ZERO, 4'd0, 1'b0);
        rst = 1'b0;
        idle_inputs();
        cyc("post_err", C_NORM, 4'd0, 1'b0);

        // Reset in the middle of a wait restarts the timeout window
        hz.mem_ls = 2'b01;
        cyc("mw1", C_FRZ, 4'd1, 1'b0);
        cyc("mw2", C_FRZ, 4'd2, 1'b0);
        rst = 1'b1;
        cyc("mw_rst", C_ZERO, 4'd0, 1'b0);
        rst = 1'b0;
        cyc("mw_a", C_FRZ, 4'd1, 1'b0);
        cyc("mw_b", C_FRZ, 4'd2, 1'b0);
        cyc("mw_c", C_FRZ, 4'd3, 1'b0);
        hz.dmem_ready = 1'b1;
        cyc("mw_rdy", C_NORM_R, 4'd3, 1'b0);

        // mem_op dropping mid-wait returns to RUN and clears the timer
        hz.dmem_ready = 1'b0;
        cyc("pv1", C_FRZ, 4'd4, 1'b0);
        cyc("pv2", C_FRZ, 4'd5, 1'b0);
        hz.mem_ls = 2'b00;
        cyc("pv_drop", C_NORM, 4'd5, 1'b0);
        hz.mem_ls = 2'b10;
        cyc("pv_a", C_FRZ, 4'd6, 1'b0);
        cyc("pv_b", C_FRZ, 4'd7, 1'b0);
        cyc("pv_c", C_FRZ, 4'd8, 1'b0);
        cyc("pv_d", C_FRZ, 4'd9, 1'b1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM pipeline registers, and a bubble into MEM/WB. It resolves load-use hazards, taken-branch redirects and multi-cycle data-memory accesses through a req/ready handshake. A timeout error and a stall-cycle performance counter are included.

Parameters:
TIMEOUT, 16, max cycles MEM_WAIT may last before error; legal range 2..255
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  rs1 field of the instruction in ID
id_rs2  in  5  rs2 field of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_reg_addr  in  5  destination register of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_ls  in  2  MEM-stage access type: 00 none, 01 load, 10 store, 11 reserved (treated as none)
dmem_ready  in  1  data memory completes the access this cycle
dmem_req  out  1  request to data memory
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads bubble (control = 0)
ex_mem_en  out  1  EX/MEM register enable
mem_wb_bubble  out  1  MEM/WB loads bubble
bus_err  out  1  sticky memory-timeout error
stall_cnt  out  CNT_W  cycles with pc_en = 0, wraps at max

Behaviour:
- Registered state: fsm (RUN, MEM_WAIT, ERROR), wait_cnt (8 bit), bus_err, stall_cnt. All other outputs are combinational (Mealy) from state and inputs.
- Reset (rst = 1 at a clk edge): fsm = RUN, wait_cnt = 0, bus_err = 0, stall_cnt = 0. While rst is high, all enables, flushes, bubble and dmem_req are forced to 0.
- mem_op = (mem_ls == 01 or 10). dmem_req = mem_op in RUN and MEM_WAIT; dmem_req = 0 in ERROR.
- Priority, highest first: ERROR > memory freeze > branch flush > load-use stall > normal.
- Normal: all enables = 1, all flushes and bubble = 0.
- Memory freeze, when fsm is RUN or MEM_WAIT and mem_op = 1 and dmem_ready = 0:
  - pc_en, if_id_en, id_ex_en, ex_mem_en = 0; mem_wb_bubble = 1; flushes = 0.
  - A pending branch or load-use condition is held, not lost: it is re-evaluated once the freeze ends.
- Transitions:
  - RUN -> MEM_WAIT on freeze; wait_cnt <= 1.
  - MEM_WAIT: each frozen cycle wait_cnt += 1.
  - MEM_WAIT -> RUN when dmem_ready = 1. The ready cycle itself is not frozen, so the pipeline advances in that cycle; wait_cnt <= 0.
  - MEM_WAIT -> ERROR when frozen and wait_cnt == TIMEOUT-1 at the edge. bus_err <= 1.
  - mem_op dropping to 0 in MEM_WAIT (protocol violation) -> RUN, wait_cnt <= 0.
  - ERROR: all enables 0, mem_wb_bubble = 1, dmem_req = 0. Only rst exits.
- Zero-latency access: mem_op with dmem_ready = 1 in RUN causes no stall and no state change.
- Branch flush (ex_branch_taken, no freeze): pc_en = 1, if_id_flush = 1, id_ex_flush = 1; other enables 1. Any load-use match in the same cycle is ignored, because the ID instruction is squashed.
- Load-use (no freeze, no branch): condition is ex_mem_read and ex_reg_addr != 0 and ((id_rs1_used and id_rs1 == ex_reg_addr) or (id_rs2_used and id_rs2 == ex_reg_addr)).
  - Response: pc_en = 0, if_id_en = 0, id_ex_flush = 1, id_ex_en = 1, ex_mem_en = 1.
  - Exactly one bubble; the next cycle the load is in MEM and the match clears naturally.
- x0 never causes a hazard.
- stall_cnt increments at each edge where pc_en = 0 and rst = 0 (freeze, load-use, ERROR). It wraps from all-ones to 0.
- Flush outputs only assert when the corresponding enable is 1.

Test Plan:
- Reset/idle: rst = 1 for 2 cycles, then all inputs 0 -> all enables 1, flushes 0, dmem_req 0, stall_cnt 0, bus_err 0.
- Load-use: ex_mem_read = 1, ex_reg_addr = 5, id_rs2 = 5, id_rs2_used = 1 for 1 cycle -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 that cycle; stall_cnt = 1 after. Repeat with ex_reg_addr = 0 -> no stall.
- Branch vs load-use: ex_branch_taken = 1 together with a load-use match -> if_id_flush = 1, id_ex_flush = 1, pc_en = 1, stall_cnt unchanged.
- Memory wait: mem_ls = 01, dmem_ready low for 3 cycles then high -> dmem_req = 1 for 4 cycles, all enables 0 and mem_wb_bubble = 1 for 3 cycles, enables 1 on the ready cycle, stall_cnt += 3. Also apply ex_branch_taken during the freeze -> flush is issued only on the ready cycle.
- Timeout: TIMEOUT = 4, mem_ls = 10, dmem_ready held 0 -> ERROR entered at the 4th edge, bus_err = 1, dmem_req = 0, enables 0 indefinitely; rst = 1 -> RUN, bus_err = 0.
- Reset mid-wait: rst = 1 asserted during MEM_WAIT -> next cycle fsm = RUN, wait_cnt = 0, stall_cnt = 0, outputs forced low while rst is high.
